muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width (legal values 8..64, even).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request, sampled on clk rising edge.
REQ-005 SHALL have port: FuncCode  input  6  R-type function field.
REQ-006 SHALL have port: op_a  input  WIDTH  rs operand (dividend/multiplicand/MTHI-MTLO source).
REQ-007 SHALL have port: op_b  input  WIDTH  rt operand (divisor/multiplier).
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: div_by_zero  output  1  one-cycle flag, valid only with done.
REQ-011 SHALL have ports: hi, lo  output  WIDTH  registered HI/LO.

Function
REQ-012 SHALL decode FuncCode: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; all other codes: start ignored.
REQ-013 SHALL implement FSM IDLE, MUL, DIV, FIN; busy=1 in MUL, DIV, FIN.
REQ-014 SHALL accept start only in IDLE; start while busy is ignored, with no effect on operation or outputs.
REQ-015 SHALL latch operand magnitudes and result sign on the accepting edge (signed ops only; unsigned treat operands as magnitudes).
REQ-016 MUL/DIV SHALL iterate exactly WIDTH cycles (one shift-add / one restoring-subtract step per cycle), then enter FIN for one cycle.
REQ-017 FIN SHALL apply sign correction and write hi/lo on its closing edge, return to IDLE, and assert done for the following single cycle, with hi/lo already updated.
REQ-018 Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH+1; a new start is acceptable in that same done cycle.
REQ-019 MULT/MULTU SHALL produce the full 2*WIDTH product: hi = upper half, lo = lower half.
REQ-020 DIV/DIVU SHALL produce lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-021 Signed DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, div_by_zero = 0.
REQ-022 DIV/DIVU with op_b = 0 SHALL skip iteration: go IDLE->FIN, leave hi/lo unchanged, and pulse done together with div_by_zero.
REQ-023 MTHI/MTLO SHALL write op_a to hi/lo on the accepting edge, stay in IDLE, and leave busy and done low.
REQ-024 hi/lo SHALL change only per REQ-017, REQ-023 or reset.

Reset
REQ-025 On reset high at a clk edge: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0.
REQ-026 Reset mid-operation SHALL abort with no result written and no done pulse.
REQ-027 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-028 With macro MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL go IDLE->FIN directly using a combinational product, so done is high in the cycle after edge 1.
REQ-029 Without MULDIV_FAST_MUL_EN, multiply SHALL follow REQ-016 and REQ-018.
REQ-030 Division timing SHALL be identical in both configurations.

Verification (WIDTH=32)
REQ-031 MULT op_a=-3, op_b=7 -> done after edge 33 (macro off), hi=FFFFFFFF, lo=FFFFFFEB.
REQ-032 DIV op_a=-7, op_b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU op_a=7, op_b=2 -> lo=3, hi=1.
REQ-033 DIVU op_a=5, op_b=0 after MTHI 0x11 and MTLO 0x22 -> done and div_by_zero high one cycle, hi=11, lo=22.
REQ-034 MULTU FFFFFFFF*FFFFFFFF, second start at cycle 5 -> second start ignored; hi=FFFFFFFE, lo=00000001.
REQ-035 DIV 100/3 started, reset at cycle 10 -> hi=lo=0, busy=0, no done pulse; DIV 80000000/FFFFFFFF then -> lo=80000000, hi=0.
REQ-036 Macro on: MULT 6*7 -> done in cycle after edge 1, hi=0, lo=2A.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

`ifdef MULDIV_FAST_MUL_EN
  localparam state_t MUL_ENTRY = S_FIN;
`else
  localparam state_t MUL_ENTRY = S_MUL;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 is_div_q, is_div_d;
  logic                 dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_mag, prod_res;
  logic [WIDTH-1:0]     quo_res, rem_res;

  assign is_signed = (FuncCode == F_MULT) || (FuncCode == F_DIV);
  assign a_mag     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // One shift-add step: conditionally add multiplicand to the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring step; the shifted remainder needs one extra bit before the compare.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = WIDTH'(div_shift - {1'b0, opnd_q});
  assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  assign prod_mag = acc_q;
`endif

  assign prod_res = neg_q ? -prod_mag : prod_mag;
  assign quo_res  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_res  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (FuncCode)
            F_MULT, F_MULTU: begin
              is_div_d   = 1'b0;
              dbz_pend_d = 1'b0;
              opnd_d     = a_mag;
              acc_d      = {{WIDTH{1'b0}}, b_mag};
              neg_d      = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              rem_neg_d  = 1'b0;
              cnt_d      = CNT_INIT;
              state_d    = MUL_ENTRY;
            end
            F_DIV, F_DIVU: begin
              is_div_d   = 1'b1;
              dbz_pend_d = (op_b == '0);
              opnd_d     = b_mag;
              acc_d      = {{WIDTH{1'b0}}, a_mag};
              neg_d      = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              rem_neg_d  = is_signed && op_a[WIDTH-1];
              cnt_d      = CNT_INIT;
              state_d    = (op_b == '0) ? S_FIN : S_DIV;
            end
            F_MTHI:  hi_d = op_a;
            F_MTLO:  lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        if (!dbz_pend_q) begin
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[2*WIDTH-1:WIDTH];
            lo_d = prod_res[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt_q      <= cnt_d;
    acc_q      <= acc_d;
    opnd_q     <= opnd_d;
    neg_q      <= neg_d;
    rem_neg_q  <= rem_neg_d;
    is_div_q   <= is_div_d;
    dbz_pend_q <= dbz_pend_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
